// File: rtl/pong_pkg.sv
// Shared screen geometry, coordinate/score types and game state encoding for the pong game logic.
package pong_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int BALL_SIZE  = 8;
  localparam int PADDLE_W   = 8;
  localparam int PADDLE_H   = 64;
  localparam int PADDLE_L_X = 16;
  localparam int PADDLE_R_X = 616;

  localparam int COORD_W = 10;
  localparam int SCORE_W = 4;

  typedef logic [COORD_W-1:0]        coord_t;
  typedef logic signed [COORD_W:0]   scoord_t;  // 11-bit signed step arithmetic
  typedef logic signed [COORD_W+1:0] wcoord_t;  // paddle_y + PADDLE_H can exceed 1023
  typedef logic [SCORE_W-1:0]        score_t;

  localparam coord_t BALL_X0 = coord_t'((H_ACTIVE - BALL_SIZE) / 2);
  localparam coord_t BALL_Y0 = coord_t'((V_ACTIVE - BALL_SIZE) / 2);

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } state_e;

endpackage

// File: rtl/pong_collide.sv
// Combinational ball step: wall bounce, paddle hit and miss detection for one frame of play.
module pong_collide
  import pong_pkg::*;
#(
  parameter int SPEED = 2
) (
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  input  logic               dx_neg,
  input  logic               dy_neg,
  input  logic [COORD_W-1:0] paddle_l_y,
  input  logic [COORD_W-1:0] paddle_r_y,
  output logic [COORD_W-1:0] nx_o,
  output logic [COORD_W-1:0] ny_o,
  output logic               dx_neg_o,
  output logic               dy_neg_o,
  output logic               miss_l,
  output logic               miss_r
);

  localparam scoord_t ZERO   = '0;
  localparam scoord_t STEP   = scoord_t'(SPEED);
  localparam scoord_t BALL   = scoord_t'(BALL_SIZE);
  localparam scoord_t Y_MAX  = scoord_t'(V_ACTIVE - BALL_SIZE);
  localparam scoord_t X_MAX  = scoord_t'(H_ACTIVE - BALL_SIZE);
  localparam scoord_t L_EDGE = scoord_t'(PADDLE_L_X + PADDLE_W);
  localparam scoord_t R_X    = scoord_t'(PADDLE_R_X);
  localparam scoord_t R_STOP = scoord_t'(PADDLE_R_X - BALL_SIZE);
  localparam wcoord_t W_BALL = wcoord_t'(BALL_SIZE);
  localparam wcoord_t W_PH   = wcoord_t'(PADDLE_H);

  scoord_t ny;
  scoord_t ny_c;
  scoord_t nx;
  scoord_t nx_c;
  wcoord_t ny_w;
  wcoord_t pl_w;
  wcoord_t pr_w;
  logic    ovl_l;
  logic    ovl_r;
  logic    hit_l;
  logic    hit_r;

  always_comb begin
    ny       = $signed({1'b0, ball_y}) + (dy_neg ? -STEP : STEP);
    ny_c     = ny;
    dy_neg_o = dy_neg;
    if (ny <= ZERO) begin
      ny_c     = ZERO;
      dy_neg_o = 1'b0;
    end else if (ny >= Y_MAX) begin
      ny_c     = Y_MAX;
      dy_neg_o = 1'b1;
    end

    // Overlap uses the already-clamped y so a ball sliding along a wall still meets the paddle.
    ny_w  = $signed({ny_c[COORD_W], ny_c});
    pl_w  = $signed({2'b00, paddle_l_y});
    pr_w  = $signed({2'b00, paddle_r_y});
    ovl_l = (ny_w + W_BALL > pl_w) && (ny_w < pl_w + W_PH);
    ovl_r = (ny_w + W_BALL > pr_w) && (ny_w < pr_w + W_PH);

    nx    = $signed({1'b0, ball_x}) + (dx_neg ? -STEP : STEP);
    hit_l = dx_neg && (nx <= L_EDGE) && ovl_l;
    hit_r = !dx_neg && (nx + BALL >= R_X) && ovl_r;

    nx_c     = nx;
    dx_neg_o = dx_neg;
    miss_l   = 1'b0;
    miss_r   = 1'b0;
    if (hit_l) begin
      nx_c     = L_EDGE;
      dx_neg_o = 1'b0;
    end else if (hit_r) begin
      nx_c     = R_STOP;
      dx_neg_o = 1'b1;
    end else if (nx <= ZERO) begin
      miss_l = 1'b1;
    end else if (nx >= X_MAX) begin
      miss_r = 1'b1;
    end

    nx_o = nx_c[COORD_W-1:0];
    ny_o = ny_c[COORD_W-1:0];
  end

endmodule

// File: rtl/pong_ball_ctrl.sv
// Per-frame ball/score registers and the SERVE/PLAY/OVER sequencer; everything advances only on frame_tick.
module pong_ball_ctrl
  import pong_pkg::*;
#(
  parameter int SPEED        = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] paddle_l_y,
  input  logic [COORD_W-1:0] paddle_r_y,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over,
  output logic               serving
);

  localparam int               CNT_W    = $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam score_t           WIN      = score_t'(WIN_SCORE);

  state_e           state_q, state_d;
  coord_t           x_q, x_d, y_q, y_d;
  logic             dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  score_t           score_l_q, score_l_d, score_r_q, score_r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  coord_t nx, ny;
  logic   nx_dx_neg, ny_dy_neg, miss_l, miss_r;

  pong_collide #(
    .SPEED (SPEED)
  ) u_collide (
    .ball_x     (x_q),
    .ball_y     (y_q),
    .dx_neg     (dx_neg_q),
    .dy_neg     (dy_neg_q),
    .paddle_l_y (paddle_l_y),
    .paddle_r_y (paddle_r_y),
    .nx_o       (nx),
    .ny_o       (ny),
    .dx_neg_o   (nx_dx_neg),
    .dy_neg_o   (ny_dy_neg),
    .miss_l     (miss_l),
    .miss_r     (miss_r)
  );

  function automatic score_t sat_inc(input score_t s);
    return (s == '1) ? s : s + score_t'(1);
  endfunction

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dx_neg_d  = dx_neg_q;
    dy_neg_d  = dy_neg_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    cnt_d     = cnt_q;
    if (frame_tick) begin
      case (state_q)
        SERVE: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = PLAY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PLAY: begin
          x_d      = nx;
          y_d      = ny;
          dx_neg_d = nx_dx_neg;
          dy_neg_d = ny_dy_neg;
          // The next serve heads toward whoever just conceded.
          if (miss_l) begin
            score_r_d = sat_inc(score_r_q);
            x_d       = BALL_X0;
            y_d       = BALL_Y0;
            dx_neg_d  = 1'b1;
            state_d   = (score_r_d == WIN) ? OVER : SERVE;
          end else if (miss_r) begin
            score_l_d = sat_inc(score_l_q);
            x_d       = BALL_X0;
            y_d       = BALL_Y0;
            dx_neg_d  = 1'b0;
            state_d   = (score_l_d == WIN) ? OVER : SERVE;
          end
        end
        OVER:    state_d = OVER;
        default: state_d = SERVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SERVE;
      x_q       <= BALL_X0;
      y_q       <= BALL_Y0;
      dx_neg_q  <= 1'b0;
      dy_neg_q  <= 1'b0;
      score_l_q <= '0;
      score_r_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dx_neg_q  <= dx_neg_d;
      dy_neg_q  <= dy_neg_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ball_x    = x_q;
  assign ball_y    = y_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign serving   = (state_q == SERVE);
  assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Bench for pong_ball_ctrl: integer game model checked every cycle, plus literal checkpoints.
module tb_pong_ball_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic [9:0] paddle_l_y, paddle_r_y, paddle_r2_y;
  logic [9:0] ball_x, ball_y, b2_x, b2_y;
  logic [3:0] score_l, score_r, s2_l, s2_r;
  logic       game_over, serving, go2, sv2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pong_ball_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .ball_x(ball_x), .ball_y(ball_y), .score_l(score_l), .score_r(score_r),
    .game_over(game_over), .serving(serving)
  );

  pong_ball_ctrl #(.SERVE_FRAMES(2), .WIN_SCORE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r2_y),
    .ball_x(b2_x), .ball_y(b2_y), .score_l(s2_l), .score_r(s2_r),
    .game_over(go2), .serving(sv2)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Game model in plain integers: st 0=serve, 1=play, 2=over; dx/dy are +1/-1.
  int m_x, m_y, m_dx, m_dy, m_sl, m_sr, m_cnt, m_st;

  task automatic model_reset();
    m_x = 316; m_y = 236; m_dx = 1; m_dy = 1;
    m_sl = 0; m_sr = 0; m_cnt = 0; m_st = 0;
  endtask

  function automatic bit overlaps(input int by, input int py);
    return (by + 8 > py) && (by < py + 64);
  endfunction

  task automatic model_step(input int pl, input int pr);
    int nx, ny;
    if (m_st == 0) begin
      m_cnt++;
      if (m_cnt == 60) begin m_cnt = 0; m_st = 1; end
    end else if (m_st == 1) begin
      ny = m_y + 2 * m_dy;
      if (ny <= 0) begin ny = 0; m_dy = 1; end
      else if (ny >= 472) begin ny = 472; m_dy = -1; end
      nx = m_x + 2 * m_dx;
      m_y = ny;
      if (m_dx < 0 && nx <= 24 && overlaps(ny, pl)) begin
        m_x = 24; m_dx = 1;
      end else if (m_dx > 0 && nx + 8 >= 616 && overlaps(ny, pr)) begin
        m_x = 608; m_dx = -1;
      end else if (nx <= 0) begin
        m_sr++; m_x = 316; m_y = 236; m_dx = -1;
        m_st = (m_sr == 9) ? 2 : 0;
      end else if (nx >= 632) begin
        m_sl++; m_x = 316; m_y = 236; m_dx = 1;
        m_st = (m_sl == 9) ? 2 : 0;
      end else begin
        m_x = nx;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else if (frame_tick) model_step(int'(paddle_l_y), int'(paddle_r_y));
  end

  always @(negedge clk) begin
    check("ball_x", int'(ball_x), m_x);
    check("ball_y", int'(ball_y), m_y);
    check("score_l", int'(score_l), m_sl);
    check("score_r", int'(score_r), m_sr);
    check("serving", int'(serving), (m_st == 0) ? 1 : 0);
    check("game_over", int'(game_over), (m_st == 2) ? 1 : 0);
  end

  task automatic tick();
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n       = 1'b1;
    frame_tick  = 1'b0;
    paddle_l_y  = 10'd0;
    paddle_r_y  = 10'd400;
    paddle_r2_y = 10'd200;
    #2 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    check("rst_x", int'(ball_x), 316);
    check("rst_y", int'(ball_y), 236);
    check("rst_serving", int'(serving), 1);
    check("rst_scores", int'(score_l) + int'(score_r), 0);

    // Serve hold: centred and serving until the 60th tick.
    for (int i = 1; i <= 60; i++) begin
      tick();
      check("serve_x", int'(ball_x), 316);
      check("serve_flag", int'(serving), (i < 60) ? 1 : 0);
    end
    tick();
    check("play1_x", int'(ball_x), 318);
    check("play1_y", int'(ball_y), 238);

    // Bottom wall bounce at play tick 118.
    repeat (116) tick();
    tick();
    check("bottom_y", int'(ball_y), 472);
    tick();
    check("after_bottom_y", int'(ball_y), 470);

    // Right paddle hit at play tick 146.
    repeat (26) tick();
    tick();
    check("rhit_x", int'(ball_x), 608);
    check("rhit_y", int'(ball_y), 416);
    tick();
    check("after_rhit_x", int'(ball_x), 606);

    // Right miss with paddle parked at the top.
    paddle_r_y = 10'd0;
    pulse_reset();
    repeat (60 + 157) tick();
    check("pre_miss_score_l", int'(score_l), 0);
    tick();
    check("miss_score_l", int'(score_l), 1);
    check("miss_x", int'(ball_x), 316);
    check("miss_y", int'(ball_y), 236);
    check("miss_serving", int'(serving), 1);
    check("miss_game_over", int'(game_over), 0);

    // Short game on dut2: two right misses end it.
    pulse_reset();
    repeat (2 + 158) tick();
    check("g2_score1", int'(s2_l), 1);
    check("g2_over1", int'(go2), 0);
    repeat (2 + 158) tick();
    check("g2_score2", int'(s2_l), 2);
    check("g2_over2", int'(go2), 1);
    check("g2_serving", int'(sv2), 0);
    check("g2_x", int'(b2_x), 316);
    check("g2_y", int'(b2_y), 236);
    repeat (5) tick();
    check("g2_hold_score", int'(s2_l), 2);
    check("g2_hold_over", int'(go2), 1);
    check("g2_hold_x", int'(b2_x), 316);
    check("g2_hold_r", int'(s2_r), 0);

    // Asynchronous reset mid-play, sampled before any further clock edge.
    check("pre_arst_score_l", int'(score_l), 1);
    check("pre_arst_serving", int'(serving), 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_x", int'(ball_x), 316);
    check("arst_y", int'(ball_y), 236);
    check("arst_score_l", int'(score_l), 0);
    check("arst_serving", int'(serving), 1);
    check("arst_g2_over", int'(go2), 0);
    check("arst_g2_score", int'(s2_l), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (3) tick();
    check("post_arst_x", int'(ball_x), 316);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
